// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle chunked adder.
// Holds the controller state encoding used by the top level.
package multicycle_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Ripple-carry building blocks: a one-bit full adder and a CHUNK-bit ripple of them.
// c_msb exposes the carry into the top bit so the caller can detect signed overflow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module chunk_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb
);
   logic [W:0] carry_s;

   assign carry_s[0] = ci;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry_s[i]),
         .s  (s[i]),
         .co (carry_s[i+1])
      );
   end

   assign co    = carry_s[W];
   assign c_msb = carry_s[W-1];
endmodule

// File: rtl/multicycle_adder.sv
// Adds two WIDTH-bit operands CHUNK bits per clock; results appear only on completion.
// Subtraction is performed as A + ~B + 1 using the same datapath.
module multicycle_adder
   import multicycle_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);
   localparam int N     = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("multicycle_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
   end

   state_t             state_r;
   state_t             state_next_s;
   logic [IDX_W-1:0]   idx_r;
   logic               carry_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]   acc_next_s;
   logic [CHUNK-1:0]   a_chunk_s;
   logic [CHUNK-1:0]   b_chunk_s;
   logic [CHUNK-1:0]   s_chunk_s;
   logic               co_s;
   logic               c_msb_s;
   logic               last_s;
   logic               busy_r;
   logic               done_r;

   assign a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
   assign b_chunk_s = b_r[idx_r*CHUNK +: CHUNK];
   assign last_s    = (idx_r == IDX_W'(N-1));

   chunk_adder #(.W(CHUNK)) u_chunk (
      .a     (a_chunk_s),
      .b     (b_chunk_s),
      .ci    (carry_r),
      .s     (s_chunk_s),
      .co    (co_s),
      .c_msb (c_msb_s)
   );

   // Merge the freshly computed chunk into the partial result.
   always_comb begin
      acc_next_s = acc_r;
      acc_next_s[idx_r*CHUNK +: CHUNK] = s_chunk_s;
   end

   // Controller next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (start) state_next_s = RUN;  else state_next_s = IDLE;
         RUN:     if (last_s) state_next_s = DONE; else state_next_s = RUN;
         DONE:    if (start) state_next_s = RUN;  else state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State, operand capture, chunk datapath and published results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         idx_r    <= {IDX_W{1'b0}};
         carry_r  <= 1'b0;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         Sum      <= {WIDTH{1'b0}};
         Cout     <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == RUN);
         done_r  <= (state_next_s == DONE);
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  a_r     <= A;
                  b_r     <= Sub ? ~B : B;
                  carry_r <= Sub ? 1'b1 : Cin;
                  idx_r   <= {IDX_W{1'b0}};
                  acc_r   <= {WIDTH{1'b0}};
               end
            end
            RUN: begin
               acc_r   <= acc_next_s;
               carry_r <= co_s;
               idx_r   <= idx_r + IDX_W'(1);
               // Outputs change only when the final chunk lands.
               if (last_s) begin
                  Sum      <= acc_next_s;
                  Cout     <= co_s;
                  Overflow <= c_msb_s ^ co_s;
               end
            end
            default: begin
               idx_r <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=16, CHUNK=4): vector table,
// random ops against a reference model, and hand-written multi-cycle sequences.
module tb_multicycle_adder;
   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int N     = WIDTH / CHUNK;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic        Sub;
   logic        busy;
   logic        done;
   logic [15:0] Sum;
   logic        Cout;
   logic        Overflow;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [15:0] prev_sum;
   logic        prev_cout;
   logic        prev_ovf;

   multicycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .Sub      (Sub),
      .busy     (busy),
      .done     (done),
      .Sum      (Sum),
      .Cout     (Cout),
      .Overflow (Overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      logic [15:0] bb;
      logic [16:0] t;
      exp_t        e;
      bb     = sub ? ~b : b;
      t      = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      e.sum  = t[15:0];
      e.cout = t[16];
      e.ovf  = (a[15] == bb[15]) && (t[15] != a[15]);
      return e;
   endfunction

   // Scoreboard: compare results on done, and require outputs to hold otherwise.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_sum  = 16'h0000;
         prev_cout = 1'b0;
         prev_ovf  = 1'b0;
      end else if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sum", {16'h0, Sum}, {16'h0, mon_e.sum});
            check("cout", {31'h0, Cout}, {31'h0, mon_e.cout});
            check("overflow", {31'h0, Overflow}, {31'h0, mon_e.ovf});
         end
         prev_sum  = Sum;
         prev_cout = Cout;
         prev_ovf  = Overflow;
      end else begin
         check("hold", {14'h0, Sum, Cout, Overflow}, {14'h0, prev_sum, prev_cout, prev_ovf});
      end
   end

   // Issue one operation and measure latency / busy length. With b2b the caller is
   // already at the done negedge of the previous op; poke injects a start during RUN.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input exp_t e, input bit poke, input bit b2b);
      int j;
      int busy_cnt;
      bit seen;
      if (!b2b) @(negedge clk);
      A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      j = 1; busy_cnt = 0; seen = 1'b0;
      while (!seen && j <= 20) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_cnt++;
            if (poke && j == 2) begin
               start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; Sub = 1'b0;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            j++;
         end
      end
      start = 1'b0;
      check("done_latency", j, N + 1);
      check("busy_cycles", busy_cnt, N);
   endtask

   vec_t vecs[10];
   exp_t e;

   initial begin
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
      vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst_n = 1'b0; start = 1'b0; A = 16'h0000; B = 16'h0000; Cin = 1'b0; Sub = 1'b0;
      #12;
      check("reset_busy", {31'h0, busy}, 32'd0);
      check("reset_done", {31'h0, done}, 32'd0);
      check("reset_sum", {16'h0, Sum}, 32'd0);
      check("reset_cout", {31'h0, Cout}, 32'd0);
      check("reset_ovf", {31'h0, Overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         e.sum = vecs[i].sum; e.cout = vecs[i].cout; e.ovf = vecs[i].ovf;
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e, 1'b0, 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rc;
         logic        rs;
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0, 1'b0);
      end

      // Start during RUN is ignored; start in the DONE cycle chains directly.
      run_op(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0), 1'b1, 1'b0);
      run_op(16'hABCD, 16'h1234, 1'b0, 1'b1, model(16'hABCD, 16'h1234, 1'b0, 1'b1), 1'b0, 1'b1);

      // Reset in the middle of an operation.
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, model(16'h7FFF, 16'h0001, 1'b0, 1'b0), 1'b0, 1'b0);
      @(negedge clk);
      A = 16'h0001; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_done", {31'h0, done}, 32'd0);
      check("abort_sum", {16'h0, Sum}, 32'd0);
      check("abort_cout", {31'h0, Cout}, 32'd0);
      check("abort_ovf", {31'h0, Overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_done", {31'h0, done}, 32'd0);
      end
      run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, model(16'h0F0F, 16'h00F1, 1'b1, 1'b0), 1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning request a new operation with the current operands.
REQ-006 SHALL have port A, input, WIDTH, meaning operand A (unsigned or two's complement).
REQ-007 SHALL have port B, input, WIDTH, meaning operand B.
REQ-008 SHALL have port Cin, input, 1, meaning carry input in add mode.
REQ-009 SHALL have port Sub, input, 1, meaning mode: 0 = A+B+Cin, 1 = A-B.
REQ-010 SHALL have port busy, output, 1, meaning an operation is in progress.
REQ-011 SHALL have port done, output, 1, meaning a single-cycle pulse: result valid.
REQ-012 SHALL have port Sum, output, WIDTH, meaning result.
REQ-013 SHALL have port Cout, output, 1, meaning carry out of the MSB (1 = no borrow in Sub mode).
REQ-014 SHALL have port Overflow, output, 1, meaning signed two's-complement overflow.

Function
REQ-015 SHALL elaborate only if WIDTH mod CHUNK == 0 and CHUNK >= 1; otherwise SHALL raise an elaboration error.
REQ-016 SHALL implement FSM states IDLE, RUN and DONE; N = WIDTH/CHUNK.
REQ-017 IDLE: start=1 at an edge SHALL latch A, B, Cin and Sub, clear the chunk index and go to RUN.
REQ-018 Operand latching: in Sub mode the latched B SHALL be ~B and the carry-in SHALL be 1 (Cin ignored); in add mode the carry-in SHALL be Cin.
REQ-019 RUN: each edge SHALL add chunk i of A and B plus the carry register, store the CHUNK result bits at slice i and update the carry register.
REQ-020 RUN: the chunk index SHALL advance each edge, and after chunk N-1 the FSM SHALL go to DONE.
REQ-021 Latency: the start edge is edge k; done SHALL be high in exactly the cycle after edge k+N.
REQ-022 DONE: Sum, Cout and Overflow SHALL be updated on the edge entering DONE.
REQ-023 DONE: Overflow SHALL be computed as the carry into the MSB XOR the carry out of the MSB.
REQ-024 Output stability: Sum, Cout and Overflow SHALL hold their values until the next completion; partial results SHALL NOT appear on the outputs.
REQ-025 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-026 DONE: DONE SHALL go to IDLE after one cycle; start=1 in DONE SHALL be accepted as in IDLE and go directly to RUN (back-to-back).
REQ-027 start while in RUN SHALL be ignored; latched operands SHALL be unaffected.
REQ-028 Changes on A, B, Cin or Sub after the start edge SHALL have no effect on the result.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, set the FSM to IDLE and clear busy, done, Sum, Cout, Overflow, the carry register and the chunk index.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and after release the next start SHALL behave normally.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE).
REQ-032 Sub-module chunk_adder SHALL be a CHUNK-bit ripple of full_adder instances, with inputs a, b, ci and outputs s, co, plus the carry into its MSB for overflow detection.

Verification (WIDTH=16, CHUNK=4)
REQ-033 Add wrap: A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> done in the cycle after edge k+4; Sum=0x0000, Cout=1, Overflow=0; busy=1 for exactly 4 cycles.
REQ-034 Signed overflow: A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Overflow=1; a second case A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556.
REQ-035 Subtract: A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Overflow=1; a second case A=0x0003, B=0x0005, Sub=1 -> Sum=0xFFFE, Cout=0.
REQ-036 Busy, back-to-back and hold: start plus new operands during RUN are ignored; start in the DONE cycle is accepted, and the second done is 5 cycles after the first; outputs hold between the two done pulses.
REQ-037 Reset mid-op: rst_n low at RUN chunk 2 -> outputs immediately 0, no done; a new start after release gives the correct Sum.
